// File: rtl/tv80_bus_target.sv
// tv80s bus responder: memory + I/O target with programmable wait states.
// Optional macro TV80_BUS_TARGET_IO_MIRROR_EN maps I/O onto the memory array.
module tv80_bus_target #(
  parameter int         MEM_AW        = 16,
  parameter int         MEM_WAIT      = 0,
  parameter int         IO_WAIT       = 1,
  parameter logic [7:0] INTACK_VECTOR = 8'hFF,
  parameter logic [7:0] IO_PAGE       = 8'h10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] A,
  input  logic [7:0]  dout,
  output logic [7:0]  di,
  input  logic        m1_n,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        rfsh_n,
  output logic        wait_n,
  output logic        io_we,
  output logic [7:0]  io_addr,
  output logic [7:0]  io_data
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [3:0]  wcnt;
  logic [3:0]  wcnt_n;
  logic [3:0]  load_w;
  logic        commit;

  logic        mem_req;
  logic        io_req;
  logic        ack_req;
  logic        req;

  logic [7:0]  mem [0:(1<<MEM_AW)-1];
  logic [MEM_AW-1:0] mem_a;
  logic [MEM_AW-1:0] wr_a;
  logic [7:0]  rd_data;
  logic        do_wr;
  logic        mem_we;
  logic        io_wr;

`ifdef TV80_BUS_TARGET_IO_MIRROR_EN
  logic [15:0] mir_full;
  logic [MEM_AW-1:0] io_a;
  assign mir_full = {IO_PAGE, A[7:0]};
  assign io_a     = mir_full[MEM_AW-1:0];
`else
  logic [7:0]  io_rf [0:255];
`endif

  // Memory wins over I/O when both strobes are low; refresh never requests.
  assign mem_req = !mreq_n & rfsh_n & (!rd_n | !wr_n);
  assign io_req  = !iorq_n & m1_n & (!rd_n | !wr_n) & mreq_n;
  assign ack_req = !iorq_n & !m1_n & mreq_n;
  assign req     = mem_req | io_req | ack_req;
  assign mem_a   = A[MEM_AW-1:0];

  // Wait count loaded for the request currently on the bus.
  always_comb begin
    load_w = '0;
    unique case (1'b1)
      mem_req: load_w = 4'(MEM_WAIT);
      io_req:  load_w = 4'(IO_WAIT);
      default: load_w = '0;
    endcase
  end

  // Next state, wait counter and the commit strobe (edge entering DONE).
  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    commit  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          wcnt_n = load_w;
          if (load_w != 4'd0) begin
            state_n = WAIT;
          end else begin
            state_n = DONE;
            commit  = 1'b1;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_n = IDLE;
          wcnt_n  = '0;
        end else if (wcnt == 4'd1) begin
          state_n = DONE;
          wcnt_n  = '0;
          commit  = 1'b1;
        end else begin
          wcnt_n = wcnt - 4'd1;
        end
      end
      DONE: begin
        if (mreq_n & iorq_n & rd_n & wr_n) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        wcnt_n  = '0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
    end
  end

  // Held low only while reset is released so reset forces wait_n high.
  assign wait_n = !(reset_n &
    ((state == IDLE && req && load_w != 4'd0) ||
     (state == WAIT && wcnt > 4'd1)));

  assign do_wr  = commit & !wr_n & reset_n;
  assign mem_we = do_wr & mem_req;
  assign io_wr  = do_wr & io_req;

  // Read data source for the request being committed.
  always_comb begin
    rd_data = mem[mem_a];
    unique case (1'b1)
      ack_req: rd_data = INTACK_VECTOR;
`ifdef TV80_BUS_TARGET_IO_MIRROR_EN
      io_req:  rd_data = mem[io_a];
`else
      io_req:  rd_data = io_rf[A[7:0]];
`endif
      default: rd_data = mem[mem_a];
    endcase
  end

`ifdef TV80_BUS_TARGET_IO_MIRROR_EN
  assign wr_a = mem_req ? mem_a : io_a;

  // Shared array: memory and mirrored I/O writes.
  always_ff @(posedge clk) begin
    if (mem_we | io_wr) begin
      mem[wr_a] <= dout;
    end
  end
`else
  assign wr_a = mem_a;

  // Memory array write port.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_a] <= dout;
    end
  end

  // Independent I/O register file write port.
  always_ff @(posedge clk) begin
    if (io_wr) begin
      io_rf[A[7:0]] <= dout;
    end
  end
`endif

  // Read data and I/O write notification registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      di      <= 8'hFF;
      io_we   <= 1'b0;
      io_addr <= '0;
      io_data <= '0;
    end else begin
      io_we <= io_wr;
      if (commit & (ack_req | !rd_n)) begin
        di <= rd_data;
      end
      if (io_wr) begin
        io_addr <= A[7:0];
        io_data <= dout;
      end
    end
  end

endmodule

// File: tb/tb_tv80_bus_target.sv
// Bench for tv80_bus_target: vector table, directed corners, random ops.
// Reference model tracks memory and I/O contents as plain byte arrays.
module tb_tv80_bus_target;

  localparam int AW  = 12;
  localparam int MW_ = 2;
  localparam int IW_ = 1;

  localparam int K_MR  = 0;
  localparam int K_MW  = 1;
  localparam int K_IR  = 2;
  localparam int K_IW  = 3;
  localparam int K_ACK = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] A;
  logic [7:0]  dout;
  logic [7:0]  di;
  logic        m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
  logic        wait_n;
  logic        io_we;
  logic [7:0]  io_addr;
  logic [7:0]  io_data;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [7:0] mm [0:4095];
  logic [7:0] im [0:255];

  tv80_bus_target #(
    .MEM_AW(AW),
    .MEM_WAIT(MW_),
    .IO_WAIT(IW_),
    .INTACK_VECTOR(8'hFF),
    .IO_PAGE(8'h10)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .A(A),
    .dout(dout),
    .di(di),
    .m1_n(m1_n),
    .mreq_n(mreq_n),
    .iorq_n(iorq_n),
    .rd_n(rd_n),
    .wr_n(wr_n),
    .rfsh_n(rfsh_n),
    .wait_n(wait_n),
    .io_we(io_we),
    .io_addr(io_addr),
    .io_data(io_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic idle_bus();
    m1_n   = 1'b1;
    mreq_n = 1'b1;
    iorq_n = 1'b1;
    rd_n   = 1'b1;
    wr_n   = 1'b1;
    rfsh_n = 1'b1;
  endtask

  task automatic drive(input int kind);
    case (kind)
      K_MR:  begin mreq_n = 1'b0; rd_n = 1'b0; end
      K_MW:  begin mreq_n = 1'b0; wr_n = 1'b0; end
      K_IR:  begin iorq_n = 1'b0; rd_n = 1'b0; end
      K_IW:  begin iorq_n = 1'b0; wr_n = 1'b0; end
      default: begin m1_n = 1'b0; iorq_n = 1'b0; end
    endcase
  endtask

  // Entered just after a rising edge with the target idle.
  task automatic bus_op(input int kind, input logic [15:0] addr,
                        input logic [7:0] wd, input int hold,
                        output logic [7:0] rdv, output int waits,
                        output int we_cnt, output bit tmo);
    A      = addr;
    dout   = wd;
    waits  = 0;
    we_cnt = 0;
    tmo    = 1'b0;
    drive(kind);
    #1;
    while (wait_n !== 1'b1 && waits < 40) begin
      waits++;
      @(posedge clk);
      #1;
    end
    if (waits >= 40) tmo = 1'b1;
    @(posedge clk);
    #1;
    rdv = di;
    if (io_we === 1'b1) we_cnt++;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      if (io_we === 1'b1) we_cnt++;
    end
    idle_bus();
    @(posedge clk);
    #1;
    if (io_we === 1'b1) we_cnt++;
  endtask

  function automatic int exp_waits(input int kind);
    if (kind == K_MR || kind == K_MW) return MW_;
    if (kind == K_IR || kind == K_IW) return IW_;
    return 0;
  endfunction

  function automatic logic [11:0] io_mem_idx(input logic [7:0] a8);
    logic [15:0] t;
    t = {8'h10, a8};
    return t[11:0];
  endfunction

  task automatic model_write(input int kind, input logic [15:0] addr,
                             input logic [7:0] wd);
    if (kind == K_MW) mm[addr[11:0]] = wd;
    if (kind == K_IW) begin
`ifdef TV80_BUS_TARGET_IO_MIRROR_EN
      mm[io_mem_idx(addr[7:0])] = wd;
`else
      im[addr[7:0]] = wd;
`endif
    end
  endtask

  function automatic logic [7:0] model_read(input int kind,
                                            input logic [15:0] addr);
    if (kind == K_ACK) return 8'hFF;
    if (kind == K_IR) begin
`ifdef TV80_BUS_TARGET_IO_MIRROR_EN
      return mm[io_mem_idx(addr[7:0])];
`else
      return im[addr[7:0]];
`endif
    end
    return mm[addr[11:0]];
  endfunction

  // Model-checked transaction used by the random phase and corners.
  task automatic run_op(input int kind, input logic [15:0] addr,
                        input logic [7:0] wd, input int hold,
                        input string nm);
    logic [7:0] rdv;
    logic [7:0] exp;
    int w, we;
    bit tmo;
    exp = model_read(kind, addr);
    bus_op(kind, addr, wd, hold, rdv, w, we, tmo);
    chk({nm, "_timeout"}, 16'(tmo), 16'd0);
    chk({nm, "_waits"}, 16'(w), 16'(exp_waits(kind)));
    if (kind == K_MR || kind == K_IR || kind == K_ACK) begin
      chk({nm, "_rdata"}, {8'h0, rdv}, {8'h0, exp});
    end
    if (kind == K_IW) begin
      chk({nm, "_io_we_cnt"}, 16'(we), 16'd1);
      chk({nm, "_io_addr"}, {8'h0, io_addr}, {8'h0, addr[7:0]});
      chk({nm, "_io_data"}, {8'h0, io_data}, {8'h0, wd});
    end else begin
      chk({nm, "_io_we_cnt"}, 16'(we), 16'd0);
    end
    model_write(kind, addr, wd);
  endtask

  typedef struct {
    int          kind;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic [7:0]  exp;
    int          ew;
  } vec_t;

  vec_t vt [12];

  initial begin
    logic [7:0] rdv;
    logic [7:0] mirror_exp;
    int w, we;
    bit tmo;
    int kind;
    logic [15:0] addr;
    logic [7:0] wd;

`ifdef TV80_BUS_TARGET_IO_MIRROR_EN
    mirror_exp = 8'h99;
`else
    mirror_exp = 8'h21;
`endif
    vt[0]  = '{K_MW,  16'h8000, 8'h5A, 8'h00, 2};
    vt[1]  = '{K_MR,  16'h0000, 8'h00, 8'h5A, 2};
    vt[2]  = '{K_MW,  16'h1234, 8'h11, 8'h00, 2};
    vt[3]  = '{K_MR,  16'hF234, 8'h00, 8'h11, 2};
    vt[4]  = '{K_MW,  16'h0007, 8'h21, 8'h00, 2};
    vt[5]  = '{K_IW,  16'h0034, 8'hC3, 8'h00, 1};
    vt[6]  = '{K_IR,  16'hAB34, 8'h00, 8'hC3, 1};
    vt[7]  = '{K_IW,  16'h0007, 8'h99, 8'h00, 1};
    vt[8]  = '{K_MR,  16'h1007, 8'h00, mirror_exp, 2};
    vt[9]  = '{K_ACK, 16'h0038, 8'h00, 8'hFF, 0};
    vt[10] = '{K_MW,  16'h003C, 8'h3C, 8'h00, 2};
    vt[11] = '{K_MR,  16'h003C, 8'h00, 8'h3C, 2};

    idle_bus();
    A       = '0;
    dout    = '0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_di", {8'h0, di}, 16'h00FF);
    chk("rst_wait_n", 16'(wait_n), 16'd1);
    chk("rst_io_we", 16'(io_we), 16'd0);
    chk("rst_io_addr", {8'h0, io_addr}, 16'h0000);
    chk("rst_io_data", {8'h0, io_data}, 16'h0000);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      bus_op(vt[i].kind, vt[i].addr, vt[i].wd, 0, rdv, w, we, tmo);
      chk($sformatf("vec%0d_timeout", i), 16'(tmo), 16'd0);
      chk($sformatf("vec%0d_waits", i), 16'(w), 16'(vt[i].ew));
      if (vt[i].kind == K_MR || vt[i].kind == K_IR ||
          vt[i].kind == K_ACK) begin
        chk($sformatf("vec%0d_rdata", i), {8'h0, rdv},
            {8'h0, vt[i].exp});
      end
      if (vt[i].kind == K_IW) begin
        chk($sformatf("vec%0d_io_we", i), 16'(we), 16'd1);
        chk($sformatf("vec%0d_io_addr", i), {8'h0, io_addr},
            {8'h0, vt[i].addr[7:0]});
        chk($sformatf("vec%0d_io_data", i), {8'h0, io_data},
            {8'h0, vt[i].wd});
      end else begin
        chk($sformatf("vec%0d_io_we", i), 16'(we), 16'd0);
      end
      model_write(vt[i].kind, vt[i].addr, vt[i].wd);
    end

    // Refresh cycles: no wait, di untouched.
    mreq_n = 1'b0;
    rfsh_n = 1'b0;
    A      = 16'h003C;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("rfsh%0d_wait_n", i), 16'(wait_n), 16'd1);
      @(posedge clk);
      #1;
      chk($sformatf("rfsh%0d_di", i), {8'h0, di}, 16'h003C);
      chk($sformatf("rfsh%0d_io_we", i), 16'(io_we), 16'd0);
    end
    idle_bus();
    @(posedge clk);
    #1;

    // Long write strobe: a single I/O write.
    run_op(K_IW, 16'h0055, 8'hA7, 4, "iw_hold");
    run_op(K_IR, 16'h0055, 8'h00, 0, "ir_hold");
    run_op(K_MW, 16'h0066, 8'hB8, 3, "mw_hold");
    run_op(K_MR, 16'h0066, 8'h00, 0, "mr_hold");

    // Abort: release the request while waiting.
    run_op(K_MW, 16'h0500, 8'h44, 0, "abort_pre");
    A    = 16'h0500;
    dout = 8'hEE;
    drive(K_MW);
    @(posedge clk);
    #1;
    chk("abort_in_wait", 16'(wait_n), 16'd0);
    idle_bus();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    run_op(K_MR, 16'h0500, 8'h00, 0, "abort_rd");

    // Random traffic over a prefilled address pool.
    for (int k = 0; k < 16; k++) begin
      run_op(K_MW, 16'h0100 + 16'(k), 8'($urandom), 0, "fill_mem");
    end
    for (int k = 0; k < 8; k++) begin
      run_op(K_IW, 16'h0040 + 16'(k), 8'($urandom), 0, "fill_io");
    end
    for (int n = 0; n < 150; n++) begin
      kind = int'($urandom_range(0, 4));
      wd   = 8'($urandom);
      if (kind == K_MR || kind == K_MW) begin
        addr = {4'($urandom_range(0, 15)),
                12'h100 + 12'($urandom_range(0, 15))};
      end else begin
        addr = {8'($urandom), 8'h40 + 8'($urandom_range(0, 7))};
      end
      run_op(kind, addr, wd, int'($urandom_range(0, 2)),
             $sformatf("rnd%0d", n));
    end

    // Reset during the wait phase of a write discards it.
    run_op(K_MW, 16'h4400, 8'h12, 0, "rst_pre");
    run_op(K_IW, 16'h0077, 8'h5E, 0, "rst_pre_io");
    A    = 16'h4400;
    dout = 8'h77;
    drive(K_MW);
    @(posedge clk);
    #1;
    chk("rst_mid_wait_low", 16'(wait_n), 16'd0);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_wait_n", 16'(wait_n), 16'd1);
    chk("rst_mid_di", {8'h0, di}, 16'h00FF);
    chk("rst_mid_io_addr", {8'h0, io_addr}, 16'h0000);
    chk("rst_mid_io_data", {8'h0, io_data}, 16'h0000);
    @(posedge clk);
    #1;
    chk("rst_mid_hold_wait_n", 16'(wait_n), 16'd1);
    idle_bus();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    run_op(K_MR, 16'h4400, 8'h00, 0, "rst_rd");
    run_op(K_IR, 16'h0077, 8'h00, 0, "rst_rd_io");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
